wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the 64-bit core, directly upstream of the register file. It merges two result streams, ALU results and load returns from memory, through a priority arbiter with starvation protection. It formats load data (byte/half/word/dword, sign or zero extended) and drives the register file write port one cycle after acceptance. It also exports the in-flight writeback as a bypass source for decode.

## Interface
Parameters:
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, datapath width
- STARVE_LIMIT, 4, consecutive blocked ALU cycles before the ALU is force-granted (range 1..15)

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  ADDR_WIDTH  destination register
- alu_data  in  DATA_WIDTH  result
- mem_valid  in  1  load return offered
- mem_ready  out  1  load return accepted this cycle
- mem_rd  in  ADDR_WIDTH  destination register
- mem_rdata  in  DATA_WIDTH  raw aligned 8-byte memory word
- mem_size  in  2  0=byte, 1=half, 2=word, 3=dword
- mem_unsigned  in  1  1=zero-extend, 0=sign-extend
- mem_offset  in  3  byte offset of the access within the word
- rf_wen  out  1  register file write enable
- rf_waddr  out  ADDR_WIDTH  write address
- rf_wdata  out  DATA_WIDTH  write data
- byp_valid  out  1  stage register holds a real write (rd≠0)
- byp_rd  out  ADDR_WIDTH  bypass register index
- byp_data  out  DATA_WIDTH  bypass data

## Operation
- Stage register S holds valid, rd and data. It drives rf_* and byp_* directly, so all these outputs are registered.
- Arbiter states:
  - MEM_PRI (reset state): mem wins.
    - mem_ready=1.
    - alu_ready = !mem_valid.
  - ALU_FORCE:
    - alu_ready=1.
    - mem_ready = !alu_valid.
- Starvation counter:
  - In MEM_PRI, a cycle with alu_valid && mem_valid increments the counter.
  - Any cycle without a blocked ALU clears it.
  - When the counter reaches STARVE_LIMIT-1 and another block occurs, go to ALU_FORCE next cycle.
  - ALU_FORCE lasts exactly one cycle, then returns to MEM_PRI with the counter cleared.
- Each cycle:
  - If a source handshakes, S loads it with valid=1.
  - Otherwise S.valid=0.
  - At most one source is accepted per cycle.
- Load formatting:
  - shifted = mem_rdata >> (8*mem_offset).
  - Keep the low 8/16/32/64 bits according to mem_size.
  - Extend per mem_unsigned.
  - Bytes shifted in beyond bit 63 read as zero. There is no misalignment trap; that is handled upstream.
- x0 suppression:
  - rf_wen = S.valid && S.rd≠0.
  - byp_valid equals rf_wen.
  - rf_waddr and rf_wdata always reflect S.

## Timing
- Latency: handshake at cycle N produces rf_wen/byp_valid in cycle N+1. Throughput is one write per cycle.
- alu_ready and mem_ready are combinational from the *_valid inputs and the arbiter state. Data is sampled only on valid&&ready.
- Sources must hold valid and payload stable until ready.
- During and after reset, until the first clk edge following rst deassertion, all outputs are 0:
  - S.valid=0.
  - Arbiter is in MEM_PRI with counter 0.
  - alu_ready and mem_ready are gated to 0 while rst=1.
- Reset mid-operation: the pending S entry is dropped with no write, and the counter clears.
- Simultaneous valids in MEM_PRI: mem is accepted and the ALU is stalled.
- Simultaneous valids in ALU_FORCE: the ALU is accepted and mem is stalled.

## Configuration
- WB_RETIRE_CNT_EN:
  - Defined: adds output retire_cnt (64 bits), reset 0, incremented on every accepted handshake from either source, including rd=0. It wraps from 2^64-1 to 0.
  - Undefined: the port and counter are absent.

## Structure
- Shared package wb_pkg holds:
  - ADDR_WIDTH and DATA_WIDTH defaults.
  - Size encodings SZ_B, SZ_H, SZ_W, SZ_D.
  - Arbiter state enum MEM_PRI/ALU_FORCE.
- Sub-module load_formatter: purely combinational. Inputs are rdata, size, unsigned and offset; output is the formatted data.
- The arbiter, S register and counters live in wb_stage.

## Test plan
- ALU write: alu_valid, rd=5, data=0x1234 → next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234, byp_valid=1.
- x0 suppression: ALU rd=0, data=0xFF → alu_ready=1, next cycle rf_wen=0, byp_valid=0.
- Load format: mem_rdata=0x80FF_0000_0000_0000, size=byte, offset=6, signed → rf_wdata=0xFFFF_FFFF_FFFF_FFFF. The same with offset=7 → 0xFFFF_FFFF_FFFF_FF80. The same with offset=7, unsigned → 0x80.
- Starvation: mem_valid and alu_valid held high with STARVE_LIMIT=4:
  - Four mem accepts, then one ALU accept with mem_ready=0.
  - The pattern repeats every 5 cycles.
- Reset mid-flight: assert rst asynchronously in the cycle after an accept → rf_wen drops to 0 immediately, with no write after release.
- With WB_RETIRE_CNT_EN: 10 accepts, including one with rd=0 → retire_cnt=10.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: width defaults, load size codes
// and the writeback arbiter state type.
package wb_pkg;

   localparam int DEF_ADDR_WIDTH = 5;
   localparam int DEF_DATA_WIDTH = 64;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   typedef enum logic {
      MEM_PRI   = 1'b0,
      ALU_FORCE = 1'b1
   } arb_state_e;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load-return formatter: shift the raw aligned word down to the
// access offset, keep the accessed width, then sign- or zero-extend it.
module load_formatter
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            size,
   input  logic                  uns,
   input  logic [2:0]            offset,
   output logic [DATA_WIDTH-1:0] data
);

   logic [DATA_WIDTH-1:0] shifted;

   // Logical shift, so bytes pulled in from above the top of the word are zero.
   assign shifted = rdata >> {offset, 3'b000};

   always_comb begin
      data = shifted;
      unique case (size)
         SZ_B: data = {{(DATA_WIDTH-8){~uns & shifted[7]}}, shifted[7:0]};
         SZ_H: data = {{(DATA_WIDTH-16){~uns & shifted[15]}}, shifted[15:0]};
         SZ_W: data = {{(DATA_WIDTH-32){~uns & shifted[31]}}, shifted[31:0]};
         SZ_D: data = shifted;
      endcase
   end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: arbitrates ALU results and load returns into one registered
// register-file write port and bypass source. Optional retire counter: WB_RETIRE_CNT_EN.
module wb_stage
   import wb_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_valid,
   output logic                  alu_ready,
   input  logic [ADDR_WIDTH-1:0] alu_rd,
   input  logic [DATA_WIDTH-1:0] alu_data,
   input  logic                  mem_valid,
   output logic                  mem_ready,
   input  logic [ADDR_WIDTH-1:0] mem_rd,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic [1:0]            mem_size,
   input  logic                  mem_unsigned,
   input  logic [2:0]            mem_offset,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic                  byp_valid,
   output logic [ADDR_WIDTH-1:0] byp_rd,
   output logic [DATA_WIDTH-1:0] byp_data,
`ifdef WB_RETIRE_CNT_EN
   output logic [63:0]           retire_cnt,
`endif
   output logic                  dbg_arb_state
);

   localparam logic [3:0] CNT_LAST = 4'(STARVE_LIMIT - 1);

   arb_state_e            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic                  s_valid_q, s_valid_d;
   logic [ADDR_WIDTH-1:0] s_rd_q, s_rd_d;
   logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
   logic [DATA_WIDTH-1:0] load_data;
   logic                  alu_fire, mem_fire;

   load_formatter #(.DATA_WIDTH(DATA_WIDTH)) u_load_formatter (
      .rdata  (mem_rdata),
      .size   (mem_size),
      .uns    (mem_unsigned),
      .offset (mem_offset),
      .data   (load_data)
   );

   // Handshake: a source transfers on a cycle where valid && ready; it must hold
   // valid and payload stable until then. Ready is combinational from both
   // valids and the arbiter state, and is held low while rst is asserted.
   always_comb begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
      state_d   = state_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         MEM_PRI: begin
            mem_ready = !rst;
            alu_ready = !rst && !mem_valid;
            if (alu_valid && mem_valid) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = ALU_FORCE;
                  cnt_d   = 4'd0;
               end else begin
                  cnt_d = 4'(cnt_q + 4'd1);
               end
            end else begin
               cnt_d = 4'd0;
            end
         end
         ALU_FORCE: begin
            alu_ready = !rst;
            mem_ready = !rst && !alu_valid;
            state_d   = MEM_PRI;
            cnt_d     = 4'd0;
         end
      endcase
   end

   assign alu_fire = alu_valid && alu_ready;
   assign mem_fire = mem_valid && mem_ready;

   // The two ready terms never overlap when both sources are valid, so at most one fires.
   always_comb begin
      s_valid_d = alu_fire || mem_fire;
      s_rd_d    = s_rd_q;
      s_data_d  = s_data_q;
      if (mem_fire) begin
         s_rd_d   = mem_rd;
         s_data_d = load_data;
      end else if (alu_fire) begin
         s_rd_d   = alu_rd;
         s_data_d = alu_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= MEM_PRI;
         cnt_q     <= 4'd0;
         s_valid_q <= 1'b0;
         s_rd_q    <= '0;
         s_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         s_valid_q <= s_valid_d;
         s_rd_q    <= s_rd_d;
         s_data_q  <= s_data_d;
      end
   end

   assign rf_wen        = s_valid_q && (s_rd_q != '0);
   assign rf_waddr      = s_rd_q;
   assign rf_wdata      = s_data_q;
   assign byp_valid     = rf_wen;
   assign byp_rd        = s_rd_q;
   assign byp_data      = s_data_q;
   assign dbg_arb_state = state_q;

`ifdef WB_RETIRE_CNT_EN
   logic [63:0] retire_q, retire_d;

   // Counts every accepted transfer, x0 writes included; wraps naturally.
   assign retire_d = retire_q + 64'(s_valid_d);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) retire_q <= 64'd0;
      else     retire_q <= retire_d;
   end

   assign retire_cnt = retire_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed vectors, a behavioural model of the
// stage checked every cycle, and hand-computed literal expectations.
module tb_wb_stage;

   localparam int AW = 5;
   localparam int DW = 64;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          alu_valid = 1'b0;
   logic          alu_ready;
   logic [AW-1:0] alu_rd = '0;
   logic [DW-1:0] alu_data = '0;
   logic          mem_valid = 1'b0;
   logic          mem_ready;
   logic [AW-1:0] mem_rd = '0;
   logic [DW-1:0] mem_rdata = '0;
   logic [1:0]    mem_size = 2'd0;
   logic          mem_unsigned = 1'b0;
   logic [2:0]    mem_offset = 3'd0;
   logic          rf_wen;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic          byp_valid;
   logic [AW-1:0] byp_rd;
   logic [DW-1:0] byp_data;
   logic          dbg_arb_state;
`ifdef WB_RETIRE_CNT_EN
   logic [63:0]   retire_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   wb_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
      .clk           (clk),
      .rst           (rst),
      .alu_valid     (alu_valid),
      .alu_ready     (alu_ready),
      .alu_rd        (alu_rd),
      .alu_data      (alu_data),
      .mem_valid     (mem_valid),
      .mem_ready     (mem_ready),
      .mem_rd        (mem_rd),
      .mem_rdata     (mem_rdata),
      .mem_size      (mem_size),
      .mem_unsigned  (mem_unsigned),
      .mem_offset    (mem_offset),
      .rf_wen        (rf_wen),
      .rf_waddr      (rf_waddr),
      .rf_wdata      (rf_wdata),
      .byp_valid     (byp_valid),
      .byp_rd        (byp_rd),
      .byp_data      (byp_data),
`ifdef WB_RETIRE_CNT_EN
      .retire_cnt    (retire_cnt),
`endif
      .dbg_arb_state (dbg_arb_state)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic          m_valid = 1'b0;
   logic [AW-1:0] m_rd = '0;
   logic [DW-1:0] m_data = '0;
   int            m_streak = 0;
   bit            m_force = 1'b0;
   logic [63:0]   m_retire = '0;

   function automatic logic [63:0] fmt(input logic [63:0] raw, input logic [1:0] sz,
                                       input logic uns, input logic [2:0] off);
      logic [63:0] v, mask;
      int nbits;
      v = raw >> (8 * off);
      nbits = 8 * (1 << sz);
      if (nbits == 64) return v;
      mask = (64'd1 << nbits) - 64'd1;
      v = v & mask;
      if (!uns && v[nbits-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic exp_alu_ready();
      return !rst && (m_force || !mem_valid);
   endfunction

   function automatic logic exp_mem_ready();
      return !rst && (!m_force || !alu_valid);
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_valid  = 1'b0;
         m_streak = 0;
         m_force  = 1'b0;
         m_retire = '0;
      end else begin
         logic a, m;
         a = alu_valid && exp_alu_ready();
         m = mem_valid && exp_mem_ready();
         m_valid = a || m;
         if (m) begin
            m_rd   = mem_rd;
            m_data = fmt(mem_rdata, mem_size, mem_unsigned, mem_offset);
         end else if (a) begin
            m_rd   = alu_rd;
            m_data = alu_data;
         end
         if (a || m) m_retire = m_retire + 64'd1;
         // ALU gets forced through after SL consecutive cycles of losing to mem
         if (!m_force && alu_valid && mem_valid) begin
            m_streak++;
            if (m_streak == SL) begin
               m_force  = 1'b1;
               m_streak = 0;
            end
         end else begin
            m_force  = 1'b0;
            m_streak = 0;
         end
      end
   end

   always @(negedge clk) begin
      check("alu_ready", alu_ready, exp_alu_ready());
      check("mem_ready", mem_ready, exp_mem_ready());
      check("rf_wen", rf_wen, m_valid && (m_rd != '0));
      check("byp_valid", byp_valid, m_valid && (m_rd != '0));
      if (m_valid) begin
         check("rf_waddr", rf_waddr, m_rd);
         check("rf_wdata", rf_wdata, m_data);
         check("byp_rd", byp_rd, m_rd);
         check("byp_data", byp_data, m_data);
      end
`ifdef WB_RETIRE_CNT_EN
      check("retire_cnt", retire_cnt, m_retire);
`endif
   end

   // ---------------- driver tasks ----------------
   task automatic send_alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
      alu_valid = 1'b1;
      alu_rd    = rd;
      alu_data  = d;
      #1 check("send_alu_ready", alu_ready, 1'b1);
      @(posedge clk);
      #1 alu_valid = 1'b0;
   endtask

   task automatic send_mem(input logic [AW-1:0] rd, input logic [DW-1:0] raw,
                           input logic [1:0] sz, input logic uns, input logic [2:0] off);
      mem_valid    = 1'b1;
      mem_rd       = rd;
      mem_rdata    = raw;
      mem_size     = sz;
      mem_unsigned = uns;
      mem_offset   = off;
      #1 check("send_mem_ready", mem_ready, 1'b1);
      @(posedge clk);
      #1 mem_valid = 1'b0;
   endtask

   bit exp_mr[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

   initial begin
      #3;
      check("rst_rf_wen", rf_wen, 1'b0);
      check("rst_byp_valid", byp_valid, 1'b0);
      check("rst_rf_wdata", rf_wdata, 64'd0);
      check("rst_alu_ready", alu_ready, 1'b0);
      check("rst_mem_ready", mem_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // ALU write
      send_alu(5'd5, 64'h1234);
      check("alu_wen", rf_wen, 1'b1);
      check("alu_waddr", rf_waddr, 64'd5);
      check("alu_wdata", rf_wdata, 64'h1234);
      check("alu_byp_valid", byp_valid, 1'b1);

      // x0 suppression
      send_alu(5'd0, 64'hFF);
      check("x0_wen", rf_wen, 1'b0);
      check("x0_byp_valid", byp_valid, 1'b0);

      // load formatting
      send_mem(5'd3, 64'h80FF_0000_0000_0000, 2'd0, 1'b0, 3'd6);
      check("ld_b_s_off6", rf_wdata, 64'hFFFF_FFFF_FFFF_FFFF);
      send_mem(5'd3, 64'h80FF_0000_0000_0000, 2'd0, 1'b0, 3'd7);
      check("ld_b_s_off7", rf_wdata, 64'hFFFF_FFFF_FFFF_FF80);
      send_mem(5'd3, 64'h80FF_0000_0000_0000, 2'd0, 1'b1, 3'd7);
      check("ld_b_u_off7", rf_wdata, 64'h80);
      send_mem(5'd4, 64'h80FF_0000_0000_0000, 2'd1, 1'b1, 3'd6);
      check("ld_h_u_off6", rf_wdata, 64'h80FF);
      send_mem(5'd4, 64'h8000_0001_1234_5678, 2'd2, 1'b0, 3'd4);
      check("ld_w_s_off4", rf_wdata, 64'hFFFF_FFFF_8000_0001);
      send_mem(5'd4, 64'h0000_7FFF_1234_5678, 2'd1, 1'b0, 3'd4);
      check("ld_h_s_pos", rf_wdata, 64'h7FFF);
      send_mem(5'd6, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 1'b0, 3'd0);
      check("ld_d", rf_wdata, 64'hDEAD_BEEF_CAFE_F00D);
      send_mem(5'd6, 64'hDEAD_BEEF_CAFE_F00D, 2'd3, 1'b0, 3'd2);
      check("ld_d_off2_zero_fill", rf_wdata, 64'h0000_DEAD_BEEF_CAFE);

      // starvation: both sources held valid
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hA11;
      mem_valid = 1'b1; mem_rd = 5'd8; mem_rdata = 64'h3333;
      mem_size = 2'd3; mem_unsigned = 1'b0; mem_offset = 3'd0;
      for (int i = 0; i < 10; i++) begin
         #1;
         check("starve_mem_ready", mem_ready, exp_mr[i]);
         check("starve_alu_ready", alu_ready, !exp_mr[i]);
         @(posedge clk);
      end
      #1;
      check("starve_last_waddr", rf_waddr, 64'd7);
      alu_valid = 1'b0;
      mem_valid = 1'b0;

      // reset mid-flight
      send_alu(5'd9, 64'h55);
      check("mid_wen_before", rf_wen, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("mid_wen_async", rf_wen, 1'b0);
      check("mid_wdata_async", rf_wdata, 64'd0);
      check("mid_alu_ready", alu_ready, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 check("mid_no_write", rf_wen, 1'b0);

      // ten accepts, one to x0
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) send_alu(5'(i), 64'(i * 3));
         else            send_mem(5'(i), 64'h0123_4567_89AB_CDEF, 2'(i % 4), 1'(i % 3 == 0), 3'(i));
      end
`ifdef WB_RETIRE_CNT_EN
      check("retire_cnt_10", retire_cnt, 64'd10);
`endif
      repeat (2) @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
